// File: rtl/multimode_shift_counter.sv
// multimode_shift_counter
// N-bit shift counter that runs as a Johnson counter (2N states) or as a
// one-hot ring counter (N states), in either shift direction. It supports
// parallel load. When the counter is advanced from a state that is illegal
// for the current mode, it returns to the home state (only bit 0 set).
// wrap and err are registered one-cycle pulses.
module multimode_shift_counter #(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    dir,
  input  logic                    load,
  input  logic [N-1:0]            load_val,
  output logic [N-1:0]            q,
  output logic [$clog2(2*N)-1:0]  idx,
  output logic                    wrap,
  output logic                    err
);

  localparam int IW = $clog2(2*N);
  localparam int CW = $clog2(N+1);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] HOME = N'(1);

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  mode_e mode_s;
  dir_e  dir_s;

  logic [N-1:0]  q_q, q_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [CW-1:0] ones;
  logic [CW-1:0] trans;
  logic [PW-1:0] pos;
  logic          legal;
  logic [N-1:0]  shifted;
  logic [IW-1:0] idx_c;

  assign mode_s = mode_e'(mode);
  assign dir_s  = dir_e'(dir);

  // Population count, adjacent-bit transition count and set-bit position of q
  always_comb begin
    ones  = '0;
    trans = '0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (q_q[i]) begin
        ones = ones + CW'(1);
        pos  = PW'(i);
      end
    end
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (q_q[i] != q_q[i+1]) trans = trans + CW'(1);
    end
  end

  // Legality of q for the current mode. Johnson does not compare bit N-1
  // with bit 0, so the all-zero and all-one states count as legal.
  always_comb begin
    legal = 1'b0;
    case (mode_s)
      MODE_JOHNSON: legal = (trans <= CW'(1));
      MODE_RING:    legal = (ones == CW'(1));
      default:      legal = 1'b0;
    endcase
  end

  // Candidate next value when q is shifted by one step
  always_comb begin
    shifted = q_q;
    case ({mode_s, dir_s})
      {MODE_JOHNSON, DIR_DOWN}: shifted = {~q_q[0], q_q[N-1:1]};
      {MODE_JOHNSON, DIR_UP}:   shifted = {q_q[N-2:0], ~q_q[N-1]};
      {MODE_RING, DIR_DOWN}:    shifted = {q_q[0], q_q[N-1:1]};
      {MODE_RING, DIR_UP}:      shifted = {q_q[N-2:0], q_q[N-1]};
      default:                  shifted = q_q;
    endcase
  end

  // Step index decoded from q. Illegal states decode to 0.
  always_comb begin
    idx_c = '0;
    if (legal) begin
      case (mode_s)
        MODE_JOHNSON: begin
          if (q_q[0]) idx_c = IW'((2*N + 1 - int'(ones)) % (2*N));
          else        idx_c = IW'(int'(ones) + 1);
        end
        MODE_RING:    idx_c = IW'((N - int'(pos)) % N);
        default:      idx_c = '0;
      endcase
    end
  end

  // Next state, in priority order rst > load > en. The flags pulse only for
  // the step that was just taken.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (rst) begin
      q_d = HOME;
    end else if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (legal) begin
        q_d    = shifted;
        wrap_d = (shifted == HOME);
      end else begin
        q_d   = HOME;
        err_d = 1'b1;
      end
    end
  end

  // State registers (the reset is applied through the next-state logic)
  always_ff @(posedge clk) begin
    q_q    <= q_d;
    wrap_q <= wrap_d;
    err_q  <= err_d;
  end

  assign q    = q_q;
  assign idx  = idx_c;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_multimode_shift_counter.sv
// Directed self-checking bench for multimode_shift_counter with N=4.
module tb_multimode_shift_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] idx;
  logic       wrap;
  logic       err;

  int errors;
  int checks;

  logic [3:0] jd_q   [8];
  logic [2:0] jd_idx [8];
  logic [3:0] ju_q   [8];
  logic [2:0] ju_idx [8];
  logic [3:0] rd_q   [4];
  logic [2:0] rd_idx [4];
  logic [3:0] ru_q   [4];
  logic [2:0] ru_idx [4];

  multimode_shift_counter #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .idx      (idx),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    jd_q   = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    jd_idx = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    ju_q   = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    ju_idx = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    rd_q   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    rd_idx = '{3'd1, 3'd2, 3'd3, 3'd0};
    ru_q   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ru_idx = '{3'd3, 3'd2, 3'd1, 3'd0};

    rst = 1'b1; en = 1'b1; mode = 1'b1; dir = 1'b0; load = 1'b1; load_val = 4'b1010;
    step();
    check("reset_q", 32'(q), 32'(4'b0001));
    check("reset_idx", 32'(idx), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Johnson, shifting toward bit 0
    rst = 1'b0; load = 1'b0; mode = 1'b0; dir = 1'b0; en = 1'b1;
    check("jd_idx_start", 32'(idx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("jd_q%0d", i), 32'(q), 32'(jd_q[i]));
      check($sformatf("jd_idx%0d", i), 32'(idx), 32'(jd_idx[i]));
      check($sformatf("jd_wrap%0d", i), 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
      check($sformatf("jd_err%0d", i), 32'(err), 32'd0);
    end
    en = 1'b0;
    step();
    check("hold_q", 32'(q), 32'(4'b0001));
    check("wrap_one_cycle", 32'(wrap), 32'd0);

    // Johnson, shifting toward bit N-1
    dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("ju_q%0d", i), 32'(q), 32'(ju_q[i]));
      check($sformatf("ju_idx%0d", i), 32'(idx), 32'(ju_idx[i]));
      check($sformatf("ju_wrap%0d", i), 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
    end

    // Ring, shifting toward bit 0
    mode = 1'b1; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rd_q%0d", i), 32'(q), 32'(rd_q[i]));
      check($sformatf("rd_idx%0d", i), 32'(idx), 32'(rd_idx[i]));
      check($sformatf("rd_wrap%0d", i), 32'(wrap), (i == 3) ? 32'd1 : 32'd0);
    end

    // Ring, shifting toward bit N-1
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ru_q%0d", i), 32'(q), 32'(ru_q[i]));
      check($sformatf("ru_idx%0d", i), 32'(idx), 32'(ru_idx[i]));
      check($sformatf("ru_wrap%0d", i), 32'(wrap), (i == 3) ? 32'd1 : 32'd0);
    end

    // Load an illegal Johnson value, then advance and expect a resync
    mode = 1'b0; dir = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'b0101;
    step();
    check("ld_q", 32'(q), 32'(4'b0101));
    check("ld_idx", 32'(idx), 32'd0);
    check("ld_wrap", 32'(wrap), 32'd0);
    check("ld_err", 32'(err), 32'd0);
    load = 1'b0; en = 1'b1;
    step();
    check("resync_q", 32'(q), 32'(4'b0001));
    check("resync_err", 32'(err), 32'd1);
    check("resync_wrap", 32'(wrap), 32'd0);
    en = 1'b0;
    step();
    check("err_one_cycle", 32'(err), 32'd0);

    // With en=0, an illegal state is held
    load = 1'b1; load_val = 4'b1010;
    step();
    load = 1'b0;
    step();
    check("ill_hold_q", 32'(q), 32'(4'b1010));
    check("ill_hold_idx", 32'(idx), 32'd0);
    check("ill_hold_err", 32'(err), 32'd0);

    // Load has priority over en, and loading the home state does not assert wrap
    load = 1'b1; en = 1'b1; load_val = 4'b0001;
    step();
    check("ld_home_q", 32'(q), 32'(4'b0001));
    check("ld_home_wrap", 32'(wrap), 32'd0);
    check("ld_home_err", 32'(err), 32'd0);

    // Mode change: Johnson 0011 is illegal in ring mode
    en = 1'b0; load = 1'b1; load_val = 4'b0011;
    step();
    check("j0011_idx", 32'(idx), 32'd7);
    load = 1'b0; mode = 1'b1;
    #1;
    check("mode_idx_comb", 32'(idx), 32'd0);
    step();
    check("mode_hold_q", 32'(q), 32'(4'b0011));
    check("mode_hold_idx", 32'(idx), 32'd0);
    check("mode_hold_err", 32'(err), 32'd0);
    en = 1'b1;
    step();
    check("mode_resync_q", 32'(q), 32'(4'b0001));
    check("mode_resync_err", 32'(err), 32'd1);
    check("mode_resync_wrap", 32'(wrap), 32'd0);

    // Ring mode, all-zero state is illegal
    en = 1'b0; load = 1'b1; load_val = 4'b0000;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("ring_zero_q", 32'(q), 32'(4'b0001));
    check("ring_zero_err", 32'(err), 32'd1);

    // Reset discards a pending wrap, load and shift
    mode = 1'b0; dir = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'b0011;
    step();
    rst = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'b0110;
    step();
    check("rst_mid_q", 32'(q), 32'(4'b0001));
    check("rst_mid_wrap", 32'(wrap), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_idx", 32'(idx), 32'd0);

    // Reset discards a pending err
    rst = 1'b0; load = 1'b1; en = 1'b0; load_val = 4'b1010;
    step();
    rst = 1'b1; load = 1'b0; en = 1'b1;
    step();
    check("rst_err_q", 32'(q), 32'(4'b0001));
    check("rst_err_err", 32'(err), 32'd0);
    rst = 1'b0; en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
